// File: rtl/uart_tx_fifo_reader_pkg.sv
// uart_tx_fifo_reader_pkg: shared state encodings, parity mode codes and default bit period.
package uart_tx_fifo_reader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  localparam int DEFAULT_CLK_DIV = 434;
endpackage

// File: rtl/uart_tx_fifo_reader_bit_timer.sv
// uart_bit_timer: bit-period counter 0..CLK_DIV-1 with explicit reload.
// bit_pre_end flags the penultimate count so registered outputs can land on the final cycle.
module uart_bit_timer #(
  parameter int CLK_DIV   = 434,
  parameter int DIV_WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);
  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] PRE  = DIV_WIDTH'(CLK_DIV - 2);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  assign bit_end     = cnt_q == LAST;
  assign bit_pre_end = cnt_q == PRE;
  always_comb cnt_d = (restart || bit_end) ? '0 : cnt_q + DIV_WIDTH'(1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops one byte per frame from a registered-read FIFO and serialises it
// as start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_fifo_reader
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DIV_WIDTH = 16,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       par_q, par_d, tx_q, tx_d, done_q, done_d;
  logic       bit_end, bit_pre_end, start_ok, last_data, last_stop;

  assign start_ok  = enable_i && !fifo_empty_i;
  assign last_data = bit_q == 3'd7;
  assign last_stop = bit_q == 3'(STOP_BITS - 1);
  assign fifo_rd_o = state_q == ST_POP;
  assign busy_o    = state_q != ST_IDLE;
  assign tx_o      = tx_q;
  assign done_o    = done_q;

  // The timer is held at zero until the start bit so every bit period begins aligned.
  uart_bit_timer #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .restart     (state_q == ST_IDLE || state_q == ST_POP || state_q == ST_LOAD),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_ok ? ST_POP : ST_IDLE;
      ST_POP:    state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_START;
      ST_START:  state_d = bit_end ? ST_DATA : ST_START;
      ST_DATA:   if (bit_end && last_data) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
      ST_STOP:   if (bit_end && last_stop) state_d = start_ok ? ST_POP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        shift_d = fifo_data_i;
        par_d   = (^fifo_data_i) ^ (PARITY == PAR_ODD);
        tx_d    = 1'b0;
        bit_d   = '0;
      end
      ST_START: if (bit_end) tx_d = shift_q[0];
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = last_data ? 3'd0 : bit_q + 3'd1;
        tx_d    = last_data ? ((PARITY != PAR_NONE) ? par_q : 1'b1) : shift_q[1];
      end
      ST_PARITY: if (bit_end) tx_d = 1'b1;
      ST_STOP: begin
        done_d = bit_pre_end && last_stop;
        if (bit_end) bit_d = bit_q + 3'd1;
      end
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: four DUT variants (none/even/odd parity, two stop bits) each behind a
// bench FIFO, checked every cycle against a frame-position model plus literal waveform points.
module tb_uart_tx_fifo_reader;
  localparam int CD = 4;
  logic clk = 0, rst_n = 0;
  logic en[4], emp[4], rd[4], tx[4], busy[4], done[4];
  logic [7:0] fdata[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] mem[4][64];
  int wp[4] = '{0, 0, 0, 0};
  int rp[4] = '{0, 0, 0, 0};
  int mp[4] = '{0, 0, 0, 0};
  int fpos[4] = '{0, 0, 0, 0};
  bit act[4] = '{0, 0, 0, 0};
  logic [7:0] fbyte[4];
  logic ltx[4][100], ldn[4][100];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    uart_tx_fifo_reader #(
      .CLK_DIV(CD), .DIV_WIDTH(16),
      .PARITY(g == 1 ? 1 : (g == 2 ? 2 : 0)), .STOP_BITS(g == 3 ? 2 : 1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_n), .enable_i(en[g]), .fifo_empty_i(emp[g]),
      .fifo_data_i(fdata[g]), .fifo_rd_o(rd[g]), .tx_o(tx[g]), .busy_o(busy[g]), .done_o(done[g])
    );
  end

  always_comb for (int i = 0; i < 4; i++) emp[i] = rp[i] == wp[i];

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rd[i]) begin
        fdata[i] <= mem[i][rp[i] % 64];
        rp[i] <= rp[i] + 1;
      end

  function automatic int par_of(int i);
    return i == 1 ? 1 : (i == 2 ? 2 : 0);
  endfunction

  function automatic int stp_of(int i);
    return i == 3 ? 2 : 1;
  endfunction

  function automatic int flen(int i);
    return 2 + CD * (10 + (par_of(i) != 0 ? 1 : 0) + stp_of(i) - 1);
  endfunction

  // Serial level at a given cycle of a frame, counting from the pop cycle.
  function automatic logic exp_tx(int i, int pos, logic [7:0] b);
    int k;
    if (pos < 2) return 1'b1;
    k = (pos - 2) / CD;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par_of(i) != 0) return (^b) ^ (par_of(i) == 2);
    return 1'b1;
  endfunction

  task automatic chk(string nm, int i, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, i, a, e, $time);
    end
  endtask

  task automatic push(int i, logic [7:0] b);
    mem[i][wp[i] % 64] = b;
    wp[i]++;
  endtask

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) act[i] = 0;
      chk("tx", i, int'(tx[i]), act[i] ? int'(exp_tx(i, fpos[i], fbyte[i])) : 1);
      chk("rd", i, int'(rd[i]), (act[i] && fpos[i] == 0) ? 1 : 0);
      chk("busy", i, int'(busy[i]), act[i] ? 1 : 0);
      chk("done", i, int'(done[i]), (act[i] && fpos[i] == flen(i) - 1) ? 1 : 0);
      if (act[i]) begin
        fpos[i]++;
        if (fpos[i] == flen(i)) act[i] = 0;
      end
      if (!act[i] && rst_n && en[i] && !emp[i]) begin
        act[i] = 1;
        fpos[i] = 0;
        fbyte[i] = mem[i][mp[i] % 64];
        mp[i]++;
      end
    end

  task automatic record(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        ltx[i][c] = tx[i];
        ldn[i][c] = done[i];
      end
    end
  endtask

  function automatic int first_done(int i, int n);
    for (int c = 0; c < n; c++) if (ldn[i][c]) return c;
    return -1;
  endfunction

  initial begin
    int nrd, nd, fall;
    logic a5_bits[10];
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) en[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    nrd = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) nrd += int'(rd[i]);
    end
    chk("idle_pops", 0, nrd, 0);

    @(posedge clk); #1;
    push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07); push(3, 8'hFF);
    record(60);
    fall = -1;
    for (int c = 59; c >= 0; c--) if (!ltx[0][c]) fall = c;
    chk("fall_latency", 0, fall, 3);
    for (int k = 0; k < 10; k++) chk("a5_bit", k, int'(ltx[0][4 + 4 * k]), int'(a5_bits[k]));
    nd = 0;
    for (int c = 0; c < 60; c++) nd += int'(ldn[0][c]);
    chk("done_pulses", 0, nd, 1);
    chk("done_cycle", 0, first_done(0, 60), 42);
    chk("even_par_bit", 1, int'(ltx[1][40]), 1);
    chk("odd_par_bit", 2, int'(ltx[2][40]), 0);
    chk("par_done_cycle", 1, first_done(1, 60), 46);
    chk("par_done_cycle", 2, first_done(2, 60), 46);
    nd = 0;
    for (int c = 39; c <= 46; c++) nd += int'(ltx[3][c]);
    chk("two_stop_high", 3, nd, 8);
    chk("two_stop_done", 3, first_done(3, 60), 46);

    @(posedge clk); #1;
    push(0, 8'h55); push(0, 8'h0F);
    nrd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ltx[0][c] = tx[0];
      ldn[0][c] = done[0];
      nrd += int'(rd[0]);
    end
    chk("b2b_pops", 0, nrd, 2);
    chk("b2b_first_done", 0, first_done(0, 100), 42);
    chk("b2b_gap_pop", 0, int'(ltx[0][43]), 1);
    chk("b2b_gap_load", 0, int'(ltx[0][44]), 1);
    chk("b2b_second_start", 0, int'(ltx[0][45]), 0);
    chk("b2b_second_bit0", 0, int'(ltx[0][49]), 1);

    @(posedge clk); #1;
    push(0, 8'h33);
    repeat (21) @(negedge clk);
    chk("pre_reset_bit3", 0, int'(tx[0]), 0);
    #2 rst_n = 0;
    #1;
    chk("async_reset_tx", 0, int'(tx[0]), 1);
    chk("async_reset_busy", 0, int'(busy[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nrd = 0;
    repeat (20) begin
      @(negedge clk);
      nrd += int'(rd[0]);
    end
    chk("post_reset_pops", 0, nrd, 0);
    @(posedge clk); #1;
    push(0, 8'h3C);
    repeat (50) @(negedge clk);
    chk("post_reset_frame", 0, rp[0], wp[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
